// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-stage hazard interface: decode-side instruction attributes in, pipeline
// enables and scoreboard status out. The master drives decode fields, the slave is the controller.
interface pipeline_hazard_ctrl_if;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_useRs;
    logic        id_useRt;
    logic        id_ifWriteRegsFile;
    logic [4:0]  id_writeAddr;
    logic        id_shouldJumpOrBranch;
    logic        MIO_ready;
    logic        pcWrite;
    logic        ifIdWrite;
    logic        ifIdFlush;
    logic        idExBubble;
    logic        pipeFreeze;
    logic        shouldStall;
    logic [31:0] busyMask;
    logic [15:0] stallCount;

    // Level-based control: no valid/ready handshake. Every output is a
    // combinational function of the current inputs and the scoreboard state.
    modport master (
        output id_valid, id_rs, id_rt, id_useRs, id_useRt, id_ifWriteRegsFile,
               id_writeAddr, id_shouldJumpOrBranch, MIO_ready,
        input  pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeFreeze,
               shouldStall, busyMask, stallCount
    );
    modport slave (
        input  id_valid, id_rs, id_rt, id_useRs, id_useRt, id_ifWriteRegsFile,
               id_writeAddr, id_shouldJumpOrBranch, MIO_ready,
        output pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeFreeze,
               shouldStall, busyMask, stallCount
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Scoreboard hazard/stall controller: per-register countdowns of in-flight writes,
// stall/bubble/flush generation and a global freeze while memory/I/O is not ready.
module pipeline_hazard_ctrl #(
    parameter int WB_DISTANCE = 3,
    parameter int CNT_W       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(WB_DISTANCE);

    logic [CNT_W-1:0] cnt [1:31];
    logic [31:0]      busy;
    logic [15:0]      stall_cnt;
    logic             rs_busy;
    logic             rt_busy;
    logic             hazard;
    logic             freeze;
    logic             issue;

    always_comb begin
        busy = '0;
        for (int r = 1; r < 32; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end

    // busy[0] is hard-wired low, so reads of $0 can never raise a hazard.
    assign rs_busy = hz.id_useRs & (hz.id_rs != 5'd0) & busy[hz.id_rs];
    assign rt_busy = hz.id_useRt & (hz.id_rt != 5'd0) & busy[hz.id_rt];
    assign hazard  = ~rst & hz.id_valid & (rs_busy | rt_busy);
    assign freeze  = ~rst & ~hz.MIO_ready;
    assign issue   = ~rst & hz.id_valid & ~hazard & ~freeze;

    assign hz.pipeFreeze  = freeze;
    assign hz.shouldStall = hazard;
    assign hz.pcWrite     = ~rst & ~freeze & ~hazard;
    assign hz.ifIdWrite   = ~rst & ~freeze & ~hazard;
    assign hz.idExBubble  = rst | (~freeze & (hazard | ~hz.id_valid));
    assign hz.ifIdFlush   = issue & hz.id_shouldJumpOrBranch;
    assign hz.busyMask    = busy;
    assign hz.stallCount  = stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 1; r < 32; r++) begin
                cnt[r] <= '0;
            end
            stall_cnt <= '0;
        end else if (!freeze) begin
            // A fresh writer reloads its counter even if an older write is pending.
            for (int r = 1; r < 32; r++) begin
                if (issue && hz.id_ifWriteRegsFile && (hz.id_writeAddr == 5'(r))) begin
                    cnt[r] <= LOAD;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CNT_W'(1);
                end
            end
            if (hazard && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic checked
// cycle by cycle against a ready-time scoreboard model; a second instance covers saturation.
module tb_pipeline_hazard_ctrl;
    localparam int WB = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if hz ();
    pipeline_hazard_ctrl_if hz2 ();

    pipeline_hazard_ctrl #(.WB_DISTANCE(WB), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .hz(hz)
    );
    pipeline_hazard_ctrl #(.WB_DISTANCE(7), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .hz(hz2)
    );

    int checks   = 0;
    int failures = 0;

    // Model: act counts non-frozen edges since reset; register r is busy while
    // act < free_at[r]; stall count is a saturating integer.
    int act;
    int free_at [32];
    int m_sc;
    bit model_ok = 1'b0;

    bit last_stall;
    bit last_flush;
    bit last_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_busy(input int r);
        return (r != 0) && (act < free_at[r]);
    endfunction

    task automatic drive(input logic v, input int rs, input int rt, input logic urs,
                         input logic urt, input logic wr, input int wa, input logic br,
                         input logic mio);
        hz.id_valid              = v;
        hz.id_rs                 = 5'(rs);
        hz.id_rt                 = 5'(rt);
        hz.id_useRs              = urs;
        hz.id_useRt              = urt;
        hz.id_ifWriteRegsFile    = wr;
        hz.id_writeAddr          = 5'(wa);
        hz.id_shouldJumpOrBranch = br;
        hz.MIO_ready             = mio;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    endtask

    // Called just after a negedge with inputs settled: check, clock, update model.
    task automatic cycle();
        bit haz, frz, iss, r_now, wr_now;
        int wa_now;
        logic [31:0] bm;
        #1;
        r_now  = rst;
        frz    = !hz.MIO_ready;
        haz    = !r_now && hz.id_valid &&
                 ((hz.id_useRs && m_busy(int'(hz.id_rs))) ||
                  (hz.id_useRt && m_busy(int'(hz.id_rt))));
        iss    = !r_now && hz.id_valid && !haz && !frz;
        wr_now = hz.id_ifWriteRegsFile;
        wa_now = int'(hz.id_writeAddr);
        if (r_now) begin
            chk("rst_pcWrite", 32'(hz.pcWrite), 32'd0);
            chk("rst_ifIdWrite", 32'(hz.ifIdWrite), 32'd0);
            chk("rst_ifIdFlush", 32'(hz.ifIdFlush), 32'd0);
            chk("rst_idExBubble", 32'(hz.idExBubble), 32'd1);
            chk("rst_pipeFreeze", 32'(hz.pipeFreeze), 32'd0);
            chk("rst_shouldStall", 32'(hz.shouldStall), 32'd0);
        end else begin
            chk("pcWrite", 32'(hz.pcWrite), 32'(!frz && !haz));
            chk("ifIdWrite", 32'(hz.ifIdWrite), 32'(!frz && !haz));
            chk("ifIdFlush", 32'(hz.ifIdFlush), 32'(iss && hz.id_shouldJumpOrBranch));
            chk("idExBubble", 32'(hz.idExBubble), 32'(!frz && (haz || !hz.id_valid)));
            chk("pipeFreeze", 32'(hz.pipeFreeze), 32'(frz));
            chk("shouldStall", 32'(hz.shouldStall), 32'(haz));
        end
        if (model_ok) begin
            for (int r = 0; r < 32; r++) bm[r] = m_busy(r);
            chk("busyMask", hz.busyMask, bm);
            chk("stallCount", 32'(hz.stallCount), 32'(m_sc));
        end
        last_stall = hz.shouldStall;
        last_flush = hz.ifIdFlush;
        last_pc    = hz.pcWrite;
        @(posedge clk);
        if (r_now) begin
            act = 0;
            foreach (free_at[r]) free_at[r] = 0;
            m_sc = 0;
            model_ok = 1'b1;
        end else if (!frz) begin
            if (haz && m_sc < 65535) m_sc++;
            if (iss && wr_now && wa_now != 0) free_at[wa_now] = act + 1 + WB;
            act++;
        end
        @(negedge clk);
    endtask

    initial begin
        int n, fl, frozen, bcnt, raw, i;
        bit exp_stall;
        rst = 1'b1;
        idle();
        hz2.id_valid = 1'b0; hz2.id_rs = 5'd0; hz2.id_rt = 5'd0;
        hz2.id_useRs = 1'b0; hz2.id_useRt = 1'b0; hz2.id_ifWriteRegsFile = 1'b0;
        hz2.id_writeAddr = 5'd0; hz2.id_shouldJumpOrBranch = 1'b0; hz2.MIO_ready = 1'b1;
        @(posedge clk);
        act = 0; foreach (free_at[r]) free_at[r] = 0; m_sc = 0; model_ok = 1'b1;
        @(negedge clk);
        cycle();
        rst = 1'b0;
        cycle();
        chk("reset_busyMask", hz.busyMask, 32'd0);
        chk("reset_stallCount", 32'(hz.stallCount), 32'd0);

        // RAW back-to-back on $8
        drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b1); cycle();
        drive(1'b1, 8, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        n = 0;
        for (int k = 0; k < 12; k++) begin cycle(); if (!last_stall) break; n++; end
        chk("raw_stall_cycles", 32'(n), 32'd3);
        chk("raw_stallCount", 32'(hz.stallCount), 32'd3);

        // $0 never tracked; unused source ignored
        drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1); cycle();
        drive(1'b1, 0, 0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1); cycle();
        chk("r0_no_stall", 32'(last_stall), 32'd0);
        chk("r0_busy", 32'(hz.busyMask[0]), 32'd0);
        drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 9, 1'b0, 1'b1); cycle();
        drive(1'b1, 9, 9, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1); cycle();
        chk("unused_src_no_stall", 32'(last_stall), 32'd0);
        idle(); repeat (4) cycle();

        // Taken branch without, then with, a hazard
        drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1); cycle();
        chk("br_flush", 32'(last_flush), 32'd1);
        chk("br_pcWrite", 32'(last_pc), 32'd1);
        idle(); cycle();
        chk("br_flush_once", 32'(last_flush), 32'd0);
        drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 5, 1'b0, 1'b1); cycle();
        drive(1'b1, 5, 0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        n = 0; fl = 0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (last_flush) fl++;
            if (!last_stall) break;
            n++;
        end
        chk("br_haz_stalls", 32'(n), 32'd3);
        chk("br_haz_flushes", 32'(fl), 32'd1);
        idle(); cycle();

        // Freeze for 4 cycles inside a RAW stall
        drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b1); cycle();
        drive(1'b1, 8, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1); cycle();
        frozen = 1;
        hz.MIO_ready = 1'b0;
        repeat (4) begin cycle(); frozen++; end
        hz.MIO_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin cycle(); if (last_pc) break; frozen++; end
        chk("freeze_total_stall", 32'(frozen), 32'd7);
        chk("freeze_stallCount", 32'(hz.stallCount), 32'd9);
        idle(); cycle();

        // WAW reload of $10
        drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b1); cycle();
        idle(); cycle();
        drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b1); cycle();
        idle(); bcnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (hz.busyMask[10]) bcnt++;
            cycle();
        end
        chk("waw_busy_cycles", 32'(bcnt), 32'd3);

        // Reset mid-stall clears the scoreboard
        drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 12, 1'b0, 1'b1); cycle();
        drive(1'b1, 12, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1); cycle();
        rst = 1'b1; cycle();
        rst = 1'b0; cycle();
        chk("rst_mid_stall_issue", 32'(last_pc), 32'd1);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 7) != 0));
            rst = ($urandom_range(0, 63) == 0);
            cycle();
        end
        rst = 1'b0;
        idle(); cycle();

        // Saturation on the WB_DISTANCE=7 instance: one self-dependent instruction
        // stalls 7 of every 8 cycles.
        hz2.id_valid = 1'b1; hz2.id_rs = 5'd8; hz2.id_useRs = 1'b1;
        hz2.id_ifWriteRegsFile = 1'b1; hz2.id_writeAddr = 5'd8;
        raw = 0; i = 0;
        while (i < 80000 && raw < 65540) begin
            exp_stall = (i % 8) != 0;
            #1;
            if (raw == 65530) chk("sat_shouldStall", 32'(hz2.shouldStall), 32'(exp_stall));
            @(posedge clk);
            if (exp_stall) raw++;
            @(negedge clk);
            if (raw == 65534 && exp_stall) chk("sat_fffe", 32'(hz2.stallCount), 32'hFFFE);
            i++;
        end
        chk("sat_reached", 32'(raw), 32'd65540);
        chk("sat_hold", 32'(hz2.stallCount), 32'hFFFF);
        hz2.id_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Scoreboard-based hazard and stall controller for the five-stage pipeline. Tracks in-flight register-file writes issued from the decode stage. Generates the PC/IF-ID enables, the decode-to-execute bubble and the IF-ID flush on taken jumps/branches. Freezes the whole pipeline while memory-mapped I/O is not ready. Sits beside the decode stage and replaces its purely address-compare stall logic.

## Interface
Parameters:
- WB_DISTANCE, 3: stall cycles imposed on an instruction that immediately follows a writer of one of its sources. Must be 1..7.
- CNT_W, 3: width of each per-register countdown. Must satisfy 2^CNT_W > WB_DISTANCE.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decode stage holds a real instruction.
- id_rs  in  5  source register A address.
- id_rt  in  5  source register B address.
- id_useRs  in  1  instruction reads rs.
- id_useRt  in  1  instruction reads rt.
- id_ifWriteRegsFile  in  1  instruction writes the register file.
- id_writeAddr  in  5  destination register (rd/rt/31).
- id_shouldJumpOrBranch  in  1  jump or taken branch resolved in decode.
- MIO_ready  in  1  memory/I/O ready; 0 freezes the pipeline.
- pcWrite  out  1  PC register load enable.
- ifIdWrite  out  1  IF/ID register load enable.
- ifIdFlush  out  1  clear IF/ID to a NOP on this edge.
- idExBubble  out  1  load a NOP into ID/EX instead of the decode output.
- pipeFreeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- shouldStall  out  1  data hazard is present this cycle.
- busyMask  out  32  bit r = 1 when register r has a pending write.
- stallCount  out  16  saturating count of hazard-stall cycles.

## Operation
State:
- cnt[1..31], each CNT_W bits wide. Register 0 has no counter, and busyMask[0] is always 0.
- stallCount, 16 bits wide.

Combinational logic:
- busy[r] = (cnt[r] != 0).
- hazard = id_valid & ((id_useRs & id_rs != 0 & busy[id_rs]) | (id_useRt & id_rt != 0 & busy[id_rt])).
- freeze = ~MIO_ready.
- issue = id_valid & ~hazard & ~freeze.

Outputs:
- pipeFreeze = freeze.
- shouldStall = hazard.
- pcWrite = ifIdWrite = ~freeze & ~hazard.
- idExBubble = ~freeze & (hazard | ~id_valid).
- ifIdFlush = issue & id_shouldJumpOrBranch. This drops the wrong-path fetch: one bubble per taken jump/branch.
- A jump/branch with a hazard stalls first. The flush is asserted only on the cycle the branch issues.

Sequential update on each edge with rst = 0 and freeze = 0, for every r in 1..31:
- If issue & id_ifWriteRegsFile & id_writeAddr == r, then cnt[r] <= WB_DISTANCE. A new writer wins over the decrement (WAW case).
- Otherwise, if cnt[r] != 0, then cnt[r] <= cnt[r] - 1.
- Writes to register 0 are never tracked.

Freeze:
- With freeze = 1, all counters and stallCount hold.
- No issue, no flush and no bubble occur.

stallCount:
- Increments when hazard & ~freeze.
- Saturates at 16'hFFFF.

## Timing
Reset (edge with rst = 1):
- All cnt = 0 and stallCount = 0.
- While rst = 1, outputs are forced: pcWrite = 0, ifIdWrite = 0, ifIdFlush = 0, idExBubble = 1, pipeFreeze = 0, shouldStall = 0.
- busyMask = 0 from the first edge.
- rst asserted mid-stall clears the scoreboard. The next cycle after release issues without a hazard.

Latencies:
- All outputs are combinational from inputs and current state, with zero-cycle latency.
- busyMask reflects the state after the last edge.
- Writer issued at edge t: a dependent instruction in decode during cycles t+1..t+WB_DISTANCE stalls. It issues in cycle t+WB_DISTANCE+1.
- A dependent instruction k cycles behind the writer stalls max(0, WB_DISTANCE-k+1) cycles.

Boundary cases:
- Same register as source and destination: the hazard check uses pre-edge state, so an instruction never stalls on itself.
- MIO_ready dropping during a stall extends the stall by exactly the frozen cycles.
- id_valid = 0: no hazard, pcWrite = 1, idExBubble = 1, no counter is set.

## Test plan
- Reset: assert rst for 2 cycles, then release with idle inputs → busyMask = 0, stallCount = 0, pcWrite = 1, idExBubble = 1.
- RAW back-to-back: issue a write to $8, then next cycle present a reader of $8 (useRs = 1) → shouldStall = 1 for 3 cycles, idExBubble = 1 for those 3 cycles, issue in the 4th cycle; stallCount = 3.
- $0 and unused sources: write $0, then read $0; separately read $9 with useRt = 0 while $9 is busy → no stall; busyMask[0] = 0.
- Taken branch: a branch with no hazard and id_shouldJumpOrBranch = 1 → ifIdFlush = 1 for exactly 1 cycle with pcWrite = 1. The same branch sourcing a busy $5 → 3 stall cycles, then the flush.
- Freeze: set MIO_ready = 0 for 4 cycles in the middle of a 3-cycle RAW stall → pipeFreeze = 1 and pcWrite = 0 during the freeze, the counter holds, the total stall is 7 cycles, stallCount rises by 3 only.
- WAW overwrite and saturation: write $10, then write $10 again 2 cycles later → cnt[10] reloads to 3. Preload stallCount near 16'hFFFF via a long hazard → it holds at FFFF.
